// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Define FIFO_LEVEL_EN to add the LEVEL occupancy output.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FI_STB,
  input  logic [WIDTH-1:0] FI_DAT,
  output logic             FI_BSY,
  output logic             FO_STB,
  input  logic             FO_ACK,
  output logic [WIDTH-1:0] FO_DAT
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]  LEVEL
`endif
);
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic empty, full, push, pop;
  // Flags decode only registered pointers, so FI_BSY/FO_STB never depend on FI_STB/FO_ACK.
  always_comb begin
    empty = wr_ptr_q == rd_ptr_q;
    full = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    push = FI_STB & ~full;
    pop = FO_ACK & ~empty;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
    FI_BSY = full;
    FO_STB = ~empty;
    FO_DAT = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  end
`ifdef FIFO_LEVEL_EN
  assign LEVEL = wr_ptr_q - rd_ptr_q;
`endif
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= FI_DAT;
  end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed and randomized checks of fifo against a queue-based reference model.
module tb_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  logic CLK = 1'b0;
  logic RST;
  logic FI_STB, FO_ACK, FI_BSY, FO_STB;
  logic [WIDTH-1:0] FI_DAT, FO_DAT;
`ifdef FIFO_LEVEL_EN
  logic [ADDR_W:0] LEVEL;
`endif
  int ncmp = 0;
  int nfail = 0;
  logic [WIDTH-1:0] q[$];

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .FI_STB(FI_STB), .FI_DAT(FI_DAT), .FI_BSY(FI_BSY),
    .FO_STB(FO_STB), .FO_ACK(FO_ACK), .FO_DAT(FO_DAT)
`ifdef FIFO_LEVEL_EN
    , .LEVEL(LEVEL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag);
    logic exp_stb, exp_bsy;
    exp_stb = q.size() != 0;
    exp_bsy = q.size() == DEPTH;
    ncmp++;
    assert (FO_STB === exp_stb) else begin
      nfail++;
      $error("FAIL %s fo_stb got %b exp %b", tag, FO_STB, exp_stb);
    end
    ncmp++;
    assert (FI_BSY === exp_bsy) else begin
      nfail++;
      $error("FAIL %s fi_bsy got %b exp %b", tag, FI_BSY, exp_bsy);
    end
    if (exp_stb) begin
      ncmp++;
      assert (FO_DAT === q[0]) else begin
        nfail++;
        $error("FAIL %s fo_dat got %h exp %h", tag, FO_DAT, q[0]);
      end
    end
`ifdef FIFO_LEVEL_EN
    ncmp++;
    assert (int'(LEVEL) === q.size()) else begin
      nfail++;
      $error("FAIL %s level got %0d exp %0d", tag, LEVEL, q.size());
    end
`endif
  endtask

  // One clock: decisions use the pre-edge occupancy; pop and push both apply at the edge.
  task automatic step(input logic stb, input logic [WIDTH-1:0] dat, input logic ack, input string tag);
    bit do_push, do_pop;
    FI_STB = stb;
    FI_DAT = dat;
    FO_ACK = ack;
    do_push = stb && q.size() < DEPTH;
    do_pop = ack && q.size() > 0;
    @(posedge CLK);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(dat);
    #1;
    check(tag);
  endtask

  // Asserts reset mid-cycle, checks flags before any clock edge, then releases.
  task automatic mid_reset(input string tag);
    FI_STB = 1'b0;
    FO_ACK = 1'b0;
    #2;
    RST = 1'b0;
    q.delete();
    #1;
    check(tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  initial begin
    RST = 1'b0;
    FI_STB = 1'b0;
    FO_ACK = 1'b0;
    FI_DAT = '0;
    #12;
    check("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "idle_ack_empty");
    for (int i = 1; i <= 21; i++) step(1'b1, WIDTH'(i), 1'b0, "fill");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "drain");
    for (int i = 0; i < 40; i++) step(1'b1, WIDTH'(i), 1'b1, "stream");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "stream_flush");
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0, "refill");
    step(1'b1, 8'hAA, 1'b1, "full_push_pop");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain_after_aa");
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0, "load5");
    mid_reset("mid_reset");
    step(1'b0, 8'h00, 1'b0, "post_reset_idle");
    step(1'b1, 8'h55, 1'b0, "push55");
    step(1'b0, 8'h00, 1'b1, "pop55");
    for (int ph = 0; ph < 3; ph++) begin
      int ps, pa;
      ps = ph == 0 ? 80 : (ph == 1 ? 30 : 55);
      pa = ph == 0 ? 30 : (ph == 1 ? 80 : 55);
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 99) < ps, WIDTH'($urandom), $urandom_range(0, 99) < pa, "random");
    end
    mid_reset("final_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
Single-clock, synchronous first-word-fall-through FIFO that buffers WIDTH-bit words between a strobe/busy producer and a strobe/acknowledge consumer. It is a generic stream buffer between pipeline stages in the datapath. Storage is a register array indexed by read and write pointers with an extra wrap bit.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 16, number of storage entries; must be a power of two, >=2. ADDR_W = log2(DEPTH).

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  asynchronous reset, active-low (0 = reset asserted).
FI_STB  in  1  producer strobe: FI_DAT is valid this cycle.
FI_DAT  in  WIDTH  write data.
FI_BSY  out  1  FIFO full; a write is not accepted while high.
FO_STB  out  1  FIFO non-empty; FO_DAT holds the oldest word.
FO_ACK  in  1  consumer acknowledge: pop the head word this cycle.
FO_DAT  out  WIDTH  head-of-queue data (first-word-fall-through).

Behaviour:
- Reset (RST=0, asynchronous, any time including mid-transfer):
  - wr_ptr, rd_ptr and count clear to 0.
  - FI_BSY=0, FO_STB=0.
  - Stored data is discarded. Memory contents need not be cleared.
  - FO_DAT is don't-care while FO_STB=0; implementation drives 0 after reset.
- Pointers are ADDR_W+1 bits. The memory index is ptr[ADDR_W-1:0].
  - Empty: wr_ptr == rd_ptr.
  - Full: index bits equal and MSBs differ.
  - Pointers wrap modulo 2*DEPTH.
- Write accept: push = FI_STB & ~FI_BSY.
  - On the rising edge, mem[wr_ptr] <= FI_DAT and wr_ptr increments.
- Read accept: pop = FO_ACK & FO_STB.
  - On the rising edge, rd_ptr increments.
  - FO_ACK while empty is ignored: no pointer change, no underflow.
- FI_STB while FI_BSY=1 is ignored. The word is dropped silently and state is unchanged. The producer must hold data/strobe until FI_BSY=0.
- FI_BSY = full and FO_STB = ~empty. Both are decoded from registered pointers only, with no combinational path from FI_STB/FO_ACK.
- FO_DAT = mem[rd_ptr index], read combinationally from registered state.
- Latency: a word pushed at edge k gives FO_STB=1 with that word on FO_DAT after edge k, when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Simultaneous push and pop:
  - Non-empty and not full: both occur and occupancy is unchanged.
  - Empty: only the push occurs, since FO_STB=0.
  - Full: only the pop occurs, since FI_BSY=1. FI_BSY deasserts the following cycle.
- Order is strictly preserved across pointer wrap-around.

Optional Feature:
FIFO_LEVEL_EN.
- Defined: adds output port LEVEL, width ADDR_W+1, equal to the current occupancy (wr_ptr - rd_ptr), range 0..DEPTH.
  - Reset value is 0.
  - Updates on the same edge as push/pop.
- Not defined: the LEVEL port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: drive RST=0 asynchronously mid-cycle -> FI_BSY=0 and FO_STB=0 immediately. After release with FO_ACK=0, the FIFO stays empty.
2. Fill past full (DEPTH=16): FO_ACK=0, FI_STB=1 with FI_DAT=1..21 on consecutive cycles.
   - FO_STB=1 with FO_DAT=1 after the first edge.
   - FI_BSY=1 after the 16th word is accepted.
   - Words 17..21 are dropped.
3. Drain: after fill, hold FO_ACK=1 -> FO_DAT presents 1,2,...,16 on consecutive cycles. FO_STB falls after 16 pops and FI_BSY falls after the first pop.
4. Streaming with wrap: FI_STB and FO_ACK both held high for 40 cycles with an incrementing FI_DAT starting at 0 -> output sequence 0,1,2,... with no gaps or duplicates. FO_STB stays 1 after the first push and occupancy stays 1.
5. Full plus simultaneous push/pop: with the FIFO full, assert FI_STB (data 0xAA) and FO_ACK together -> the head pops, 0xAA is not stored, and FI_BSY=0 the next cycle.
6. Reset mid-operation: with 5 words stored, pulse RST=0 -> FO_STB=0. A subsequent push of 0x55 then appears as the head with FO_DAT=0x55. With FIFO_LEVEL_EN defined, LEVEL tracks 5 -> 0 -> 1.
